// File: rtl/sseg_pkg.sv
// Shared seven-segment types and constants for the scan controller and the
// hex/BCD decoders that feed it. All patterns are active-low, bit 7 = dp.
package sseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF     = 8'hFF;
  localparam seg_t SEG_BLANK   = 8'hFF;
  localparam seg_t SEG_DASH    = 8'hBF;
  localparam seg_t SEG_DP_ONLY = 8'h7F;

  // Adds the decimal point to an existing active-low pattern.
  function automatic seg_t seg_with_dp(input seg_t pattern);
    return pattern & 8'h7F;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Connects the display-formatting side (master) to the scan controller (slave);
// the slave also drives the board-facing anode/segment lines.
interface sseg_scan_ctrl_if
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIM_BITS   = 4
);

  logic [8*NUM_DIGITS-1:0] digit_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    upd;
  logic [DIM_BITS:0]       bright;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    sseg;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output digit_i, blank_i, upd, bright,
    input  an, sseg, frame_tick, pending
  );

  modport slave (
    input  digit_i, blank_i, upd, bright,
    output an, sseg, frame_tick, pending
  );

endinterface

// File: rtl/sseg_pwm_slot.sv
// Per-digit slot timer: free-running slot counter, guard interval and PWM
// brightness compare. lit_phase ignores blanking; the top applies that.
module sseg_pwm_slot #(
  parameter int SLOT_BITS = 16,
  parameter int DIM_BITS  = 4,
  parameter int GUARD     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIM_BITS:0]   bright,
  output logic                slot_wrap,
  output logic                lit_phase
);

  localparam logic [DIM_BITS:0]    FULL_DUTY = {1'b1, {DIM_BITS{1'b0}}};
  localparam logic [SLOT_BITS-1:0] GUARD_CNT = SLOT_BITS'(GUARD);
  localparam logic [SLOT_BITS-1:0] CNT_ONE   = {{(SLOT_BITS-1){1'b0}}, 1'b1};

  logic [SLOT_BITS-1:0] slot_cnt_r;
  logic [DIM_BITS-1:0]  phase_s;
  logic [DIM_BITS:0]    bright_sat_s;

  // Slot counter, wraps naturally at 2**SLOT_BITS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r <= {SLOT_BITS{1'b0}};
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_ONE;
    end
  end

  // Brightness above full scale saturates to always-on.
  always_comb begin
    bright_sat_s = bright;
    if (bright > FULL_DUTY) begin
      bright_sat_s = FULL_DUTY;
    end else begin
      bright_sat_s = bright;
    end
  end

  assign phase_s   = slot_cnt_r[SLOT_BITS-1 -: DIM_BITS];
  assign slot_wrap = &slot_cnt_r;
  assign lit_phase = (slot_cnt_r >= GUARD_CNT) && ({1'b0, phase_s} < bright_sat_s);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with per-digit blanking,
// PWM brightness, anti-ghosting guard and frame-aligned double buffering.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_BITS  = 16,
  parameter int DIM_BITS   = 4,
  parameter int GUARD      = 4
) (
  input  logic             clk,
  input  logic             rst,
  sseg_scan_ctrl_if.slave  bus
);

  localparam int IDX_BITS = $clog2(NUM_DIGITS);
  localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_DIGITS - 1);
  localparam logic [IDX_BITS-1:0]   IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic                  slot_wrap_s;
  logic                  lit_phase_s;
  logic                  frame_wrap_s;
  logic                  lit_s;
  logic [IDX_BITS-1:0]   idx_r;
  seg_t                  stage_seg_r [NUM_DIGITS];
  seg_t                  act_seg_r   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] stage_blank_r;
  logic [NUM_DIGITS-1:0] act_blank_r;
  logic                  pending_r;
  logic                  frame_tick_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [NUM_DIGITS-1:0] an_next_s;
  seg_t                  sseg_r;
  seg_t                  sseg_next_s;

  sseg_pwm_slot #(
    .SLOT_BITS (SLOT_BITS),
    .DIM_BITS  (DIM_BITS),
    .GUARD     (GUARD)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .bright    (bus.bright),
    .slot_wrap (slot_wrap_s),
    .lit_phase (lit_phase_s)
  );

  assign frame_wrap_s = slot_wrap_s && (idx_r == LAST_IDX);
  assign lit_s        = lit_phase_s && !act_blank_r[idx_r];

  // Digit index advances once per slot and returns to 0 on the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDX_BITS{1'b0}};
    end else if (frame_wrap_s) begin
      idx_r <= {IDX_BITS{1'b0}};
    end else if (slot_wrap_s) begin
      idx_r <= idx_r + IDX_BITS'(IDX_ONE);
    end
  end

  // Staging/active buffers; active only changes on a frame wrap so a frame
  // never mixes old and new data. A coincident upd refills staging afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        stage_seg_r[k] <= SEG_OFF;
        act_seg_r[k]   <= SEG_OFF;
      end
      stage_blank_r <= {NUM_DIGITS{1'b1}};
      act_blank_r   <= {NUM_DIGITS{1'b1}};
      pending_r     <= 1'b0;
    end else begin
      if (frame_wrap_s && pending_r) begin
        act_seg_r   <= stage_seg_r;
        act_blank_r <= stage_blank_r;
      end
      if (bus.upd) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          stage_seg_r[k] <= bus.digit_i[8*k +: 8];
        end
        stage_blank_r <= bus.blank_i;
        pending_r     <= 1'b1;
      end else if (frame_wrap_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Next anode/segment values for the current slot position.
  always_comb begin
    an_next_s   = AN_OFF;
    sseg_next_s = SEG_OFF;
    if (lit_s) begin
      an_next_s   = ~(AN_ONE << idx_r);
      sseg_next_s = act_seg_r[idx_r];
    end else begin
      an_next_s   = AN_OFF;
      sseg_next_s = SEG_OFF;
    end
  end

  // Output registers; frame_tick rises as the counters restart at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r         <= AN_OFF;
      sseg_r       <= SEG_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      an_r         <= an_next_s;
      sseg_r       <= sseg_next_s;
      frame_tick_r <= frame_wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.sseg       = sseg_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomised bench for sseg_scan_ctrl: a time-based reference model predicts
// every output cycle, plus directed duty-cycle and reset-timing checks.
module tb_sseg_scan_ctrl;

  localparam int ND        = 4;
  localparam int SB        = 4;
  localparam int DB        = 2;
  localparam int GD        = 1;
  localparam int SLOT_LEN  = 1 << SB;
  localparam int FRAME_LEN = ND * SLOT_LEN;
  localparam int PH_SHIFT  = SB - DB;
  localparam int FULL      = 1 << DB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sseg_scan_ctrl_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

  sseg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SLOT_BITS  (SB),
    .DIM_BITS   (DB),
    .GUARD      (GD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset plus the two buffers.
  int            m_t;
  logic [7:0]    m_act   [ND];
  logic [7:0]    m_stage [ND];
  logic [ND-1:0] m_act_blank;
  logic [ND-1:0] m_stage_blank;
  logic          m_pend;

  task automatic model_reset();
    m_t = 0;
    for (int k = 0; k < ND; k++) begin
      m_act[k]   = 8'hFF;
      m_stage[k] = 8'hFF;
    end
    m_act_blank   = '1;
    m_stage_blank = '1;
    m_pend        = 1'b0;
  endtask

  // One clock: predict the registered outputs, advance the model, compare.
  task automatic scoreboard_cycle();
    int slot, dig, phase, bsat;
    logic lit, wrap, e_ft, e_pend;
    logic [ND-1:0] e_an;
    logic [7:0] e_seg;
    slot  = m_t % SLOT_LEN;
    dig   = (m_t / SLOT_LEN) % ND;
    phase = slot >> PH_SHIFT;
    bsat  = (int'(bus.bright) > FULL) ? FULL : int'(bus.bright);
    lit   = (slot >= GD) && (phase < bsat) && !m_act_blank[dig];
    e_an  = '1;
    e_seg = 8'hFF;
    if (lit) begin
      e_an[dig] = 1'b0;
      e_seg     = m_act[dig];
    end
    wrap = (m_t % FRAME_LEN) == (FRAME_LEN - 1);
    e_ft = wrap;
    if (wrap && m_pend) begin
      m_act       = m_stage;
      m_act_blank = m_stage_blank;
    end
    if (bus.upd) begin
      for (int k = 0; k < ND; k++) m_stage[k] = bus.digit_i[8*k +: 8];
      m_stage_blank = bus.blank_i;
      m_pend        = 1'b1;
    end else if (wrap) begin
      m_pend = 1'b0;
    end
    e_pend = m_pend;
    @(posedge clk);
    #1;
    checks += 4;
    if (bus.an !== e_an) begin
      errors++;
      $display("FAIL an t=%0d: got %b expected %b", m_t, bus.an, e_an);
    end
    if (bus.sseg !== e_seg) begin
      errors++;
      $display("FAIL sseg t=%0d: got %h expected %h", m_t, bus.sseg, e_seg);
    end
    if (bus.frame_tick !== e_ft) begin
      errors++;
      $display("FAIL frame_tick t=%0d: got %b expected %b", m_t, bus.frame_tick, e_ft);
    end
    if (bus.pending !== e_pend) begin
      errors++;
      $display("FAIL pending t=%0d: got %b expected %b", m_t, bus.pending, e_pend);
    end
    m_t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) scoreboard_cycle();
  endtask

  task automatic do_upd(input logic [8*ND-1:0] data, input logic [ND-1:0] blank);
    bus.digit_i = data;
    bus.blank_i = blank;
    bus.upd     = 1'b1;
    scoreboard_cycle();
    bus.upd     = 1'b0;
  endtask

  // Advance until the model's next cycle is the given position in the frame.
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME_LEN && (m_t % FRAME_LEN) != pos; i++) scoreboard_cycle();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    if (bus.sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg: got %h expected ff", bus.sseg); end
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b expected 0", bus.frame_tick); end
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int cnt0, cnt3;
    bus.bright = 3'd4;
    do_upd(32'hC0F9A4B0, 4'b0000);
    run_to(0);
    cnt0 = 0;
    cnt3 = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      scoreboard_cycle();
      if (bus.an === 4'b1110) cnt0++;
      if (bus.an === 4'b0111) cnt3++;
    end
    checks += 2;
    if (cnt0 != 15) begin errors++; $display("FAIL basic_digit0_duty: got %0d expected 15", cnt0); end
    if (cnt3 != 15) begin errors++; $display("FAIL basic_digit3_duty: got %0d expected 15", cnt3); end
  endtask

  task automatic test_bright();
    int levels [4] = '{2, 0, 7, 4};
    int expect_on [4] = '{28, 0, 60, 60};
    int on_cnt;
    for (int j = 0; j < 4; j++) begin
      bus.bright = 3'(levels[j]);
      on_cnt = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        scoreboard_cycle();
        if (bus.an !== 4'b1111) on_cnt++;
      end
      checks++;
      if (on_cnt != expect_on[j]) begin
        errors++;
        $display("FAIL bright_%0d_duty: got %0d expected %0d", levels[j], on_cnt, expect_on[j]);
      end
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      bus.bright = 3'($urandom_range(0, 7));
      scoreboard_cycle();
    end
    bus.bright = 3'd4;
  endtask

  task automatic test_blank();
    do_upd(32'h8299B0F9, 4'b0100);
    run(2 * FRAME_LEN);
  endtask

  task automatic test_midframe_upd();
    run_to(20 + $urandom_range(0, 30));
    do_upd({$urandom}, 4'b0000);
    run(2 * FRAME_LEN);
  endtask

  task automatic test_wrap_upd();
    do_upd(32'h11223344, 4'b0000);
    run_to(FRAME_LEN - 1);
    do_upd(32'h55667788, 4'b0010);
    checks++;
    if (bus.pending !== 1'b1) begin errors++; $display("FAIL wrap_upd_pending: got %b expected 1", bus.pending); end
    run(2 * FRAME_LEN);
  endtask

  task automatic test_back_to_back();
    run_to(10);
    do_upd({$urandom}, 4'b1000);
    do_upd({$urandom}, 4'b0000);
    run(2 * FRAME_LEN);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME_LEN; i++) begin
      if ($urandom_range(0, 15) == 0) bus.bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        bus.blank_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        bus.digit_i = {$urandom};
        bus.upd     = 1'b1;
      end
      scoreboard_cycle();
      bus.upd = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int first_ft;
    bus.bright = 3'd4;
    do_upd(32'hC0F9A4B0, 4'b0000);
    run(FRAME_LEN);
    run_to(2 * SLOT_LEN + 9);
    rst = 1'b1;
    #1;
    checks += 2;
    if (bus.an !== 4'b1111) begin errors++; $display("FAIL midreset_an: got %b expected 1111", bus.an); end
    if (bus.sseg !== 8'hFF) begin errors++; $display("FAIL midreset_sseg: got %h expected ff", bus.sseg); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    first_ft = 0;
    for (int i = 1; i <= FRAME_LEN + 6; i++) begin
      scoreboard_cycle();
      if (bus.frame_tick === 1'b1 && first_ft == 0) first_ft = i;
    end
    checks++;
    if (first_ft != FRAME_LEN) begin
      errors++;
      $display("FAIL midreset_first_tick: got %0d expected %0d", first_ft, FRAME_LEN);
    end
    do_upd(32'h9290F8C6, 4'b0000);
    run(2 * FRAME_LEN);
  endtask

  initial begin
    bus.digit_i = '0;
    bus.blank_i = '0;
    bus.upd     = 1'b0;
    bus.bright  = 3'd4;
    model_reset();
    test_reset();
    test_basic();
    test_bright();
    test_blank();
    test_midframe_upd();
    test_wrap_upd();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
